px_pipe_router: RTL
===================

PX_PIPE_ROUTER -- requirements
Module: px_pipe_router

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter PX_W, default 24: input pixel width (RGB888).
REQ-002 The block SHALL have parameter GRAY_W, default 8: grayscale/Sobel pixel width, with GRAY_W < PX_W.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 16, range 1..255: cycles allowed for in-flight pixels to drain before a mode switch.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-005 The block SHALL have parameter RESET_MODE, default 2'b00: mode after reset.
Ports: name, direction, width, meaning.
REQ-006 clk_i  in  1  single clock; all logic on the rising edge.
REQ-007 nreset_i  in  1  asynchronous, active-low reset.
REQ-008 mode_req_i  in  2  requested mode: 00 gray+sobel, 01 sobel only, 10 gray only, 11 bypass.
REQ-009 mode_req_valid_i  in  1  mode_req_i is valid this cycle.
REQ-010 px_rdy_i, in_pixel_i  in  1, PX_W  input pixel strobe and data.
REQ-011 in_ready_o  out  1  high when the block accepts pixels.
REQ-012 gray_rdy_o, gray_px_o  out  1, PX_W  pixel feed to the gray core; gray_rdy_i, gray_px_i  in  1, GRAY_W  gray core result.
REQ-013 sobel_rdy_o, sobel_px_o  out  1, GRAY_W  pixel feed to the Sobel core; sobel_rdy_i, sobel_px_i  in  1, GRAY_W  Sobel result.
REQ-014 px_rdy_o, out_pixel_o  out  1, PX_W  registered output strobe and pixel.
REQ-015 mode_o  out  2  active mode; switching_o  out  1  high outside RUN.
REQ-016 px_in_count_o, px_drop_count_o  out  CNT_W each  accepted and dropped pixel counts.

Function
REQ-017 FSM states: RUN, DRAIN, SETTLE.
REQ-018 RUN: in_ready_o=1; a pixel is accepted when px_rdy_i=1.
REQ-019 Routing per mode_o, identical to the existing four-mode wiring.
- 00: gray fed from the input; Sobel fed from the gray output.
- 01: Sobel fed from in_pixel_i[GRAY_W-1:0].
- 10: gray only; sobel_rdy_o=0.
- 11: bypass; gray_rdy_o=0 and sobel_rdy_o=0.
REQ-020 The feed strobes (gray_rdy_o, sobel_rdy_o) SHALL be gated by in_ready_o and be combinational from the accepted inputs.
REQ-021 The output stage SHALL be registered: px_rdy_o and out_pixel_o follow the selected source strobe by exactly 1 cycle; bypass latency is 1 cycle.
REQ-022 GRAY_W results SHALL be zero-padded in the MSBs to PX_W.
REQ-023 In RUN, mode_req_valid_i=1 with mode_req_i != mode_o SHALL latch the pending mode, enter DRAIN next cycle and load the drain counter with DRAIN_CYCLES-1.
REQ-024 A request equal to mode_o SHALL be ignored.
REQ-025 A pixel presented in the same cycle as a request SHALL be accepted.
REQ-026 DRAIN:
- in_ready_o=0;
- px_rdy_i pulses SHALL be dropped and counted in px_drop_count_o;
- core outputs under the old mode SHALL still be forwarded to the output stage;
- the counter decrements each cycle;
- a new request SHALL overwrite the pending mode without restarting the counter.
REQ-027 When the drain counter equals 0, mode_o SHALL take the pending mode and the FSM SHALL enter SETTLE.
REQ-028 SETTLE (1 cycle):
- in_ready_o=0;
- px_rdy_o SHALL be forced to 0 that cycle;
- requests SHALL be ignored;
- the FSM then returns to RUN.
REQ-029 If the pending mode equals the new mode_o on reaching SETTLE, no further switch SHALL occur.
REQ-030 px_in_count_o SHALL increment on each accepted pixel; both counters SHALL saturate at all-ones and never wrap.
REQ-031 switching_o SHALL equal 1 in DRAIN and SETTLE.

Reset
REQ-032 Reset state: FSM=RUN, mode_o=RESET_MODE, pending mode=RESET_MODE, drain counter=0.
REQ-033 Reset values: px_rdy_o=0, out_pixel_o=0, both counters=0, switching_o=0.
REQ-034 Reset asserted mid-DRAIN SHALL abandon the pending switch immediately (asynchronously).

Structure
REQ-035 A shared package SHALL hold the mode enum (MODE_FULL, MODE_SOBEL, MODE_GRAY, MODE_BYPASS), the FSM state enum and the PX_W/GRAY_W defaults.
REQ-036 The drain counter and FSM SHALL be one sub-module, mode_switch_fsm; routing and the output register stay in the top.

Verification
REQ-037 After reset, with mode_o=00:
- stimulus: gray_rdy_i pulse with gray_px_i=0x5A;
- response: sobel_rdy_o=1 in the same cycle;
- stimulus: sobel_rdy_i pulse with sobel_px_i=0x3C;
- response: one cycle later px_rdy_o=1 and out_pixel_o=0x00003C.
REQ-038 Mode 11 (reached via a switch):
- stimulus: in_pixel_i=0xABCDEF with px_rdy_i=1;
- response: one cycle later out_pixel_o=0xABCDEF and px_rdy_o=1; gray_rdy_o=0 and sobel_rdy_o=0 throughout.
REQ-039 DRAIN_CYCLES=4, request 10 from 00 at cycle t:
- response: in_ready_o=0 for cycles t+1..t+5;
- response: mode_o=10 at t+5 (SETTLE);
- response: in_ready_o=1 at t+6.
REQ-040 In DRAIN, 3 px_rdy_i pulses SHALL produce px_drop_count_o=3 with px_in_count_o unchanged; a request 01 then 11 during DRAIN SHALL end with mode_o=11.
REQ-041 Reset pulsed mid-DRAIN SHALL return mode_o=RESET_MODE, switching_o=0 and counters=0; with CNT_W=4, 20 accepted pixels SHALL give px_in_count_o=15.

Source files
------------

// File: rtl/px_pipe_router_pkg.sv
// -----------------------------------------------------------------------------
// px_pipe_router_pkg
// Shared definitions for the pixel pipe router: the four routing modes, the
// mode-switch FSM state encoding and the default pixel widths.
// -----------------------------------------------------------------------------
package px_pipe_router_pkg;

  // Default pixel widths: RGB888 input, 8-bit grayscale / Sobel data.
  localparam int PX_W_DEF   = 24;
  localparam int GRAY_W_DEF = 8;

  // Routing modes as seen on mode_req_i / mode_o.
  typedef enum logic [1:0] {
    MODE_FULL   = 2'b00,  // input -> gray -> Sobel -> output
    MODE_SOBEL  = 2'b01,  // input[GRAY_W-1:0] -> Sobel -> output
    MODE_GRAY   = 2'b10,  // input -> gray -> output
    MODE_BYPASS = 2'b11   // input -> output
  } px_mode_e;

  // Mode-switch FSM states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_SETTLE = 2'b10
  } sw_state_e;

endpackage : px_pipe_router_pkg

// File: rtl/px_pipe_router_mode_switch_fsm.sv
// -----------------------------------------------------------------------------
// mode_switch_fsm
// Owns the active routing mode. A request for a different mode latches a
// pending mode and starts a drain window of DRAIN_CYCLES cycles during which
// no new pixels are accepted; at the end of the window the pending mode
// becomes active and one SETTLE cycle follows before pixels flow again.
//
// Ports:
//   clk_i             clock, rising edge
//   nreset_i          asynchronous active-low reset
//   mode_req_i        requested mode
//   mode_req_valid_i  mode_req_i valid this cycle
//   mode_o            active mode
//   in_ready_o        high in RUN (pixels accepted)
//   switching_o       high in DRAIN and SETTLE
//   settle_next_o     high in the last DRAIN cycle (next cycle is SETTLE)
// -----------------------------------------------------------------------------
module mode_switch_fsm
  import px_pipe_router_pkg::*;
#(
  parameter int         DRAIN_CYCLES = 16,
  parameter logic [1:0] RESET_MODE   = 2'b00
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic [1:0] mode_req_i,
  input  logic       mode_req_valid_i,
  output logic [1:0] mode_o,
  output logic       in_ready_o,
  output logic       switching_o,
  output logic       settle_next_o
);

  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;

  // Counter is loaded with DRAIN_CYCLES-1 so that DRAIN lasts exactly
  // DRAIN_CYCLES cycles (the zero cycle included).
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [1:0] pend_r;
  logic [1:0] pend_nxt_s;
  logic [1:0] mode_r;
  logic [1:0] mode_nxt_s;

  // Next-state, drain counter, pending and active mode computation.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      S_RUN: begin
        if (mode_req_valid_i && (mode_req_i != mode_r)) begin
          pend_nxt_s  = mode_req_i;
          cnt_nxt_s   = DRAIN_LOAD;
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        // A late request only retargets the switch; the window keeps running.
        if (mode_req_valid_i) begin
          pend_nxt_s = mode_req_i;
        end else begin
          pend_nxt_s = pend_r;
        end
        if (cnt_r == 8'd0) begin
          mode_nxt_s  = pend_nxt_s;
          state_nxt_s = S_SETTLE;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      S_SETTLE: begin
        // mode_r already equals the pending mode here, so no re-switch.
        pend_nxt_s  = mode_r;
        state_nxt_s = S_RUN;
      end
      default: begin
        pend_nxt_s  = mode_r;
        cnt_nxt_s   = 8'd0;
        state_nxt_s = S_RUN;
      end
    endcase
  end

  // FSM state registers; reset abandons any switch in progress.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= S_RUN;
      cnt_r   <= 8'd0;
      pend_r  <= RESET_MODE;
      mode_r  <= RESET_MODE;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pend_r  <= pend_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  assign mode_o        = mode_r;
  assign in_ready_o    = (state_r == S_RUN);
  assign switching_o   = (state_r != S_RUN);
  assign settle_next_o = (state_r == S_DRAIN) && (cnt_r == 8'd0);

endmodule : mode_switch_fsm

// File: rtl/px_pipe_router.sv
// -----------------------------------------------------------------------------
// px_pipe_router
// Routes an RGB pixel stream through an external grayscale core and/or an
// external Sobel core (or straight through) according to the active mode,
// registers the selected result, and counts accepted and dropped pixels.
// Mode changes go through mode_switch_fsm, which drains in-flight pixels.
//
// Ports:
//   clk_i, nreset_i                 clock / async active-low reset
//   mode_req_i, mode_req_valid_i    mode change request
//   px_rdy_i, in_pixel_i            input pixel strobe / data
//   in_ready_o                      pixels accepted this cycle
//   gray_rdy_o, gray_px_o           feed to gray core
//   gray_rdy_i, gray_px_i           gray core result
//   sobel_rdy_o, sobel_px_o         feed to Sobel core
//   sobel_rdy_i, sobel_px_i         Sobel core result
//   px_rdy_o, out_pixel_o           registered output strobe / pixel
//   mode_o, switching_o             active mode / switch in progress
//   px_in_count_o, px_drop_count_o  saturating accepted / dropped counts
// -----------------------------------------------------------------------------
module px_pipe_router
  import px_pipe_router_pkg::*;
#(
  parameter int         PX_W         = PX_W_DEF,
  parameter int         GRAY_W       = GRAY_W_DEF,
  parameter int         DRAIN_CYCLES = 16,
  parameter int         CNT_W        = 16,
  parameter logic [1:0] RESET_MODE   = 2'b00
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic [1:0]        mode_req_i,
  input  logic              mode_req_valid_i,
  input  logic              px_rdy_i,
  input  logic [PX_W-1:0]   in_pixel_i,
  output logic              in_ready_o,
  output logic              gray_rdy_o,
  output logic [PX_W-1:0]   gray_px_o,
  input  logic              gray_rdy_i,
  input  logic [GRAY_W-1:0] gray_px_i,
  output logic              sobel_rdy_o,
  output logic [GRAY_W-1:0] sobel_px_o,
  input  logic              sobel_rdy_i,
  input  logic [GRAY_W-1:0] sobel_px_i,
  output logic              px_rdy_o,
  output logic [PX_W-1:0]   out_pixel_o,
  output logic [1:0]        mode_o,
  output logic              switching_o,
  output logic [CNT_W-1:0]  px_in_count_o,
  output logic [CNT_W-1:0]  px_drop_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Widen a gray-domain result to the output pixel width, MSBs zero.
  function automatic logic [PX_W-1:0] pad_gray(input logic [GRAY_W-1:0] v);
    return {{(PX_W - GRAY_W){1'b0}}, v};
  endfunction

  logic              settle_next_s;
  logic              accept_s;
  logic              drop_s;
  logic              gray_rdy_s;
  logic              sobel_rdy_s;
  logic [GRAY_W-1:0] sobel_px_s;
  logic              src_rdy_s;
  logic [PX_W-1:0]   src_px_s;
  logic              px_rdy_r;
  logic [PX_W-1:0]   out_pixel_r;
  logic [CNT_W-1:0]  in_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  mode_switch_fsm #(
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .RESET_MODE   (RESET_MODE)
  ) u_mode_switch_fsm (
    .clk_i            (clk_i),
    .nreset_i         (nreset_i),
    .mode_req_i       (mode_req_i),
    .mode_req_valid_i (mode_req_valid_i),
    .mode_o           (mode_o),
    .in_ready_o       (in_ready_o),
    .switching_o      (switching_o),
    .settle_next_o    (settle_next_s)
  );

  // Any pixel strobe outside RUN is discarded.
  assign accept_s = px_rdy_i & in_ready_o;
  assign drop_s   = px_rdy_i & ~in_ready_o;

  // Core feed routing; all feeds stop while a switch is in progress.
  always_comb begin
    gray_rdy_s  = 1'b0;
    sobel_rdy_s = 1'b0;
    sobel_px_s  = {GRAY_W{1'b0}};
    case (mode_o)
      MODE_FULL: begin
        gray_rdy_s  = accept_s;
        sobel_rdy_s = in_ready_o & gray_rdy_i;
        sobel_px_s  = gray_px_i;
      end
      MODE_SOBEL: begin
        sobel_rdy_s = accept_s;
        sobel_px_s  = in_pixel_i[GRAY_W-1:0];
      end
      MODE_GRAY: begin
        gray_rdy_s = accept_s;
      end
      MODE_BYPASS: begin
        gray_rdy_s  = 1'b0;
        sobel_rdy_s = 1'b0;
      end
      default: begin
        gray_rdy_s  = 1'b0;
        sobel_rdy_s = 1'b0;
      end
    endcase
  end

  assign gray_rdy_o  = gray_rdy_s;
  assign gray_px_o   = in_pixel_i;
  assign sobel_rdy_o = sobel_rdy_s;
  assign sobel_px_o  = sobel_px_s;

  // Output source select; core results are not gated so that in-flight
  // pixels still reach the output during DRAIN.
  always_comb begin
    src_rdy_s = 1'b0;
    src_px_s  = {PX_W{1'b0}};
    case (mode_o)
      MODE_FULL, MODE_SOBEL: begin
        src_rdy_s = sobel_rdy_i;
        src_px_s  = pad_gray(sobel_px_i);
      end
      MODE_GRAY: begin
        src_rdy_s = gray_rdy_i;
        src_px_s  = pad_gray(gray_px_i);
      end
      MODE_BYPASS: begin
        src_rdy_s = accept_s;
        src_px_s  = in_pixel_i;
      end
      default: begin
        src_rdy_s = 1'b0;
        src_px_s  = {PX_W{1'b0}};
      end
    endcase
  end

  // Output register; strobe held low for the SETTLE cycle, pixel held
  // between strobes.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      px_rdy_r    <= 1'b0;
      out_pixel_r <= {PX_W{1'b0}};
    end else if (settle_next_s) begin
      px_rdy_r    <= 1'b0;
      out_pixel_r <= out_pixel_r;
    end else begin
      px_rdy_r    <= src_rdy_s;
      out_pixel_r <= src_rdy_s ? src_px_s : out_pixel_r;
    end
  end

  // Saturating accepted / dropped pixel counters.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      in_cnt_r   <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (accept_s && (in_cnt_r != CNT_MAX)) begin
        in_cnt_r <= in_cnt_r + CNT_W'(1);
      end
      if (drop_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  assign px_rdy_o        = px_rdy_r;
  assign out_pixel_o     = out_pixel_r;
  assign px_in_count_o   = in_cnt_r;
  assign px_drop_count_o = drop_cnt_r;

endmodule : px_pipe_router
